// File: rtl/pipe_arb.sv
// pipe_arb: round-robin arbiter sharing one clock-enabled pipe of LAT stages between two requesters.
// Defining PIPE_ARB_COUNT_EN adds saturating 8-bit per-requester result counters.
module pipe_arb #(
    parameter int unsigned DW  = 1,
    parameter int unsigned LAT = 4
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_a_stb,
    input  logic [DW-1:0] i_a_data,
    input  logic          i_b_stb,
    input  logic [DW-1:0] i_b_data,
    output logic          o_a_busy,
    output logic          o_b_busy,
    output logic          o_pipe_ce,
    output logic [DW-1:0] o_pipe_data,
    input  logic [DW-1:0] i_pipe_data,
    output logic          o_a_stb,
    output logic [DW-1:0] o_a_data,
    output logic          o_b_stb,
    output logic [DW-1:0] o_b_data
`ifdef PIPE_ARB_COUNT_EN
    ,
    output logic [7:0]    o_a_count,
    output logic [7:0]    o_b_count
`endif
);

    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_t;

    owner_t           last_grant;
    logic [LAT-1:0]   trk_vld;
    owner_t           trk_own [LAT];
    logic             grant_a;
    logic             grant_b;
    logic             tail_a;
    logic             tail_b;

    // Busy depends only on the other requester and the pointer, so there is no stb->busy loop.
    always_comb begin
        o_a_busy    = ~i_reset_n | (i_b_stb & (last_grant == OWN_A));
        o_b_busy    = ~i_reset_n | (i_a_stb & (last_grant == OWN_B));
        grant_a     = i_a_stb & ~o_a_busy;
        grant_b     = i_b_stb & ~o_b_busy;
        o_pipe_ce   = grant_a | grant_b | (|trk_vld);
        o_pipe_data = '0;
        if (grant_a)
            o_pipe_data = i_a_data;
        else if (grant_b)
            o_pipe_data = i_b_data;
        tail_a = trk_vld[LAT-1] & (trk_own[LAT-1] == OWN_A);
        tail_b = trk_vld[LAT-1] & (trk_own[LAT-1] == OWN_B);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            last_grant <= OWN_B;
        end else if (grant_a) begin
            last_grant <= OWN_A;
        end else if (grant_b) begin
            last_grant <= OWN_B;
        end
    end

    // Tracker mirrors the pipe: it advances only on ce edges, so its tail lines up with i_pipe_data.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            trk_vld <= '0;
            for (int unsigned i = 0; i < LAT; i++)
                trk_own[i] <= OWN_A;
        end else if (o_pipe_ce) begin
            trk_vld    <= {trk_vld[LAT-2:0], grant_a | grant_b};
            trk_own[0] <= grant_b ? OWN_B : OWN_A;
            for (int unsigned i = 1; i < LAT; i++)
                trk_own[i] <= trk_own[i-1];
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_a_stb  <= 1'b0;
            o_b_stb  <= 1'b0;
            o_a_data <= '0;
            o_b_data <= '0;
        end else begin
            o_a_stb <= tail_a;
            o_b_stb <= tail_b;
            if (tail_a)
                o_a_data <= i_pipe_data;
            if (tail_b)
                o_b_data <= i_pipe_data;
        end
    end

`ifdef PIPE_ARB_COUNT_EN
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_a_count <= '0;
            o_b_count <= '0;
        end else begin
            if (tail_a && (o_a_count != '1))
                o_a_count <= o_a_count + 8'd1;
            if (tail_b && (o_b_count != '1))
                o_b_count <= o_b_count + 8'd1;
        end
    end
`endif

endmodule
